// File: rtl/tt_heart_rate.sv
// ---------------------------------------------------------------------------
// tt_heart_rate
//   Heart-rate meter fed by the threshold filter's peak level. Each rising
//   edge of peak is qualified as a beat through a refractory window. The last
//   four beat-to-beat intervals (in sample ticks) are averaged, and a 16-step
//   restoring divider converts the average into beats per minute.
//   Prolonged silence flags signal loss and drops back to idle.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   ena        low = synchronous clear of everything except peak_q
//   peak       peak level from the threshold filter
//   bpm        beats per minute, saturated at 255 (0 until first result)
//   bpm_valid  bpm was computed from four intervals
//   beat       one-cycle pulse per accepted beat
//   lost       timeout seen and no beat accepted since
// ---------------------------------------------------------------------------
module tt_heart_rate #(
    parameter int CLK_DIV = 1000,
    parameter int TICK_HZ = 100,
    parameter int REFRACT = 25,
    parameter int TIMEOUT = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       peak,
    output logic [7:0] bpm,
    output logic       bpm_valid,
    output logic       beat,
    output logic       lost
);

    localparam int            PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
    localparam logic [15:0]   K         = 16'(60 * TICK_HZ);
    localparam logic [15:0]   REFRACT_V = 16'(REFRACT);
    localparam logic [16:0]   TIMEOUT_V = 17'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;  // no beat seen
    localparam logic [1:0] S_ARMED = 2'd1;  // one beat, no interval yet
    localparam logic [1:0] S_TRACK = 2'd2;  // collecting intervals

    logic [PW-1:0] pre;
    logic          peak_q;
    logic [15:0]   ivl;
    logic [1:0]    state;
    logic [15:0]   hist [4];
    logic [2:0]    nvalid;
    logic          avg_go;
    logic          div_busy;
    logic [4:0]    div_cnt;
    logic [15:0]   div_rem;
    logic [15:0]   div_quo;
    logic [15:0]   div_den;

    logic          tick;
    logic          rise;
    logic          timeout;
    logic          accept;
    logic          push;
    logic [1:0]    state_eff;
    logic [16:0]   rem_sh;
    logic [15:0]   rem_sub;
    logic          rem_ge;

    assign tick    = (pre == PRE_MAX);
    assign rise    = peak & ~peak_q;
    assign timeout = tick && (state != S_IDLE) &&
                     (({1'b0, ivl} + 17'd1) == TIMEOUT_V);

    // A rise coinciding with the timeout is judged against the post-timeout
    // state, so it is taken as a fresh IDLE beat rather than an interval.
    assign state_eff = timeout ? S_IDLE : state;
    assign accept    = rise && ((state_eff == S_IDLE) || (ivl >= REFRACT_V));
    assign push      = accept && (state_eff != S_IDLE);

    // Restoring divider step: the dividend is shifted out of div_quo's MSB
    // while quotient bits are shifted in at the LSB.
    assign rem_sh  = {div_rem, div_quo[15]};
    assign rem_ge  = (rem_sh >= {1'b0, div_den});
    assign rem_sub = rem_sh[15:0] - div_den;

    // peak_q resets high so a peak held across reset is not seen as a rise;
    // it keeps tracking peak while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) peak_q <= 1'b1;
        else        peak_q <= peak;
    end

    // Prescaler, beat qualification, FSM and interval history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre    <= '0;
            ivl    <= '0;
            state  <= S_IDLE;
            nvalid <= '0;
            avg_go <= 1'b0;
            beat   <= 1'b0;
            lost   <= 1'b0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else if (!ena) begin
            pre    <= '0;
            ivl    <= '0;
            state  <= S_IDLE;
            nvalid <= '0;
            avg_go <= 1'b0;
            beat   <= 1'b0;
            lost   <= 1'b0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else begin
            pre  <= tick ? '0 : pre + 1'b1;
            beat <= accept;

            if (timeout) begin
                ivl    <= ivl + 16'd1;
                lost   <= 1'b1;
                state  <= S_IDLE;
                nvalid <= '0;
                for (int i = 0; i < 4; i++) hist[i] <= '0;
            end else if (tick && (state != S_IDLE) && (ivl != 16'hFFFF)) begin
                ivl <= ivl + 16'd1;
            end

            if (accept) begin
                lost  <= 1'b0;
                ivl   <= '0;
                state <= (state_eff == S_IDLE) ? S_ARMED : S_TRACK;
            end

            if (push) begin
                hist[0] <= ivl;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
                hist[3] <= hist[2];
                if (nvalid != 3'd4) nvalid <= nvalid + 3'd1;
            end

            // Average once the push fills the history or it was already full.
            avg_go <= push && (nvalid >= 3'd3);
        end
    end

    // Divider and result register. Loading one cycle after the push lets the
    // freshly shifted history feed the average.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy  <= 1'b0;
            div_cnt   <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
            div_den   <= '0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
        end else if (!ena) begin
            div_busy  <= 1'b0;
            div_cnt   <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
            div_den   <= '0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
        end else begin
            if (div_busy && (div_cnt == 5'd0)) begin
                bpm       <= (|div_quo[15:8]) ? 8'hFF : div_quo[7:0];
                bpm_valid <= 1'b1;
                div_busy  <= 1'b0;
            end else if (div_busy) begin
                div_rem <= rem_ge ? rem_sub : rem_sh[15:0];
                div_quo <= {div_quo[14:0], rem_ge};
                div_cnt <= div_cnt - 5'd1;
            end

            // A new average restarts the divider from scratch.
            if (avg_go) begin
                // sum is 18 bits wide; avg = sum / 4 truncated
                div_den  <= 16'(({2'b00, hist[0]} + {2'b00, hist[1]} +
                                 {2'b00, hist[2]} + {2'b00, hist[3]}) >> 2);
                div_quo  <= K;
                div_rem  <= '0;
                div_cnt  <= 5'd16;
                div_busy <= 1'b1;
            end

            if (timeout) begin
                div_busy  <= 1'b0;
                bpm       <= '0;
                bpm_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tt_heart_rate.sv
// ---------------------------------------------------------------------------
// tb_tt_heart_rate
//   Self-checking bench for tt_heart_rate. A reference model that works in
//   terms of ticks, an interval queue and a scheduled result is compared
//   with the primary DUT every cycle. Table-driven rhythms and hand-written
//   sequences cover latency, refractory, timeout, reset and abort cases; a
//   second instance with a shorter refractory window covers saturation and
//   averaging.
// ---------------------------------------------------------------------------
module tb_tt_heart_rate;

    localparam int CLK_DIV = 4;
    localparam int TICK_HZ = 100;
    localparam int REFRACT = 25;
    localparam int TIMEOUT = 300;
    localparam int K       = 60 * TICK_HZ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       peak = 1'b0;
    logic [7:0] bpm;
    logic       bpm_valid;
    logic       beat;
    logic       lost;

    logic       ena2 = 1'b1;
    logic       peak2 = 1'b0;
    logic [7:0] bpm2;
    logic       bpm_valid2;
    logic       beat2;
    logic       lost2;

    int checks = 0;
    int errors = 0;
    int beat_seen = 0;

    always #5 clk = ~clk;

    tt_heart_rate #(.CLK_DIV(CLK_DIV), .TICK_HZ(TICK_HZ), .REFRACT(REFRACT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .peak(peak),
        .bpm(bpm), .bpm_valid(bpm_valid), .beat(beat), .lost(lost)
    );

    tt_heart_rate #(.CLK_DIV(CLK_DIV), .TICK_HZ(TICK_HZ), .REFRACT(10), .TIMEOUT(TIMEOUT)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena2), .peak(peak2),
        .bpm(bpm2), .bpm_valid(bpm_valid2), .beat(beat2), .lost(lost2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  now = 0;
    int  m_n, m_ticks, m_old, m_due, m_due_val, m_bpm, m_sum;
    bit  m_prev, m_locked, m_beat, m_lost, m_valid, m_tick, m_rise;
    int  m_hist[$];

    always @(posedge clk) begin
        now++;
        if (!rst_n || !ena) begin
            m_prev   = rst_n ? peak : 1'b1;
            m_n      = 0;
            m_ticks  = 0;
            m_locked = 1'b0;
            m_beat   = 1'b0;
            m_lost   = 1'b0;
            m_bpm    = 0;
            m_valid  = 1'b0;
            m_due    = -1;
            m_hist.delete();
        end else begin
            m_tick = ((m_n % CLK_DIV) == CLK_DIV - 1);
            m_n++;
            m_rise = peak && !m_prev;
            m_prev = peak;
            m_old  = m_ticks;
            m_beat = 1'b0;
            if (m_due == now) begin
                m_bpm   = (m_due_val > 255) ? 255 : m_due_val;
                m_valid = 1'b1;
                m_due   = -1;
            end
            if (m_tick && m_locked) begin
                if (m_ticks < 65535) m_ticks++;
                if (m_ticks == TIMEOUT) begin
                    m_lost   = 1'b1;
                    m_locked = 1'b0;
                    m_hist.delete();
                    m_bpm    = 0;
                    m_valid  = 1'b0;
                    m_due    = -1;
                end
            end
            if (m_rise && (!m_locked || m_old >= REFRACT)) begin
                m_beat = 1'b1;
                m_lost = 1'b0;
                if (m_locked) begin
                    m_hist.push_back(m_old);
                    if (m_hist.size() > 4) void'(m_hist.pop_front());
                    if (m_hist.size() == 4) begin
                        m_sum = 0;
                        foreach (m_hist[i]) m_sum += m_hist[i];
                        m_due     = now + 18;
                        m_due_val = ((m_sum / 4) == 0) ? 65535 : K / (m_sum / 4);
                    end
                end
                m_locked = 1'b1;
                m_ticks  = 0;
            end
        end
        #1;
        if (beat) beat_seen++;
        check("model", {bpm, bpm_valid, beat, lost}, {m_bpm[7:0], m_valid, m_beat, m_lost});
    end

    // ---------------- stimulus helpers ----------------
    // Clear via ena, then return one negedge later so the next rise lands
    // two edges after the clear, away from the tick phase.
    task automatic clear_dut(input bit sel);
        @(negedge clk);
        if (sel) begin ena2 = 1'b0; peak2 = 1'b0; end
        else     begin ena  = 1'b0; peak  = 1'b0; end
        @(negedge clk);
        if (sel) ena2 = 1'b1; else ena = 1'b1;
        @(negedge clk);
    endtask

    // Raise peak now, hold it for 'hold' clocks, return n negedges later.
    task automatic rise_then(input bit sel, input int n, input int hold);
        if (sel) peak2 = 1'b1; else peak = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == hold) begin
                if (sel) peak2 = 1'b0; else peak = 1'b0;
            end
        end
    endtask

    typedef struct {
        int gap;        // ticks between rises
        int nbeats;
        int exp_beats;
        int pre_bpm;    // bpm one clock before the final result lands
        bit pre_valid;
        int exp_bpm;    // bpm 18 clocks after the last rise
        bit exp_valid;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{75,  5, 5, 0,  1'b0, 80,  1'b1};
        tbl[1] = '{60,  5, 5, 0,  1'b0, 100, 1'b1};
        tbl[2] = '{75,  4, 4, 0,  1'b0, 0,   1'b0};
        tbl[3] = '{26,  5, 5, 0,  1'b0, 230, 1'b1};
        tbl[4] = '{100, 6, 6, 60, 1'b1, 60,  1'b1};
        tbl[5] = '{250, 5, 5, 0,  1'b0, 24,  1'b1};

        // reset state, peak held high across release
        peak = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        beat_seen = 0;
        repeat (10) @(negedge clk);
        check("rst_bpm", bpm, 0);
        check("rst_valid", bpm_valid, 0);
        check("rst_lost", lost, 0);
        check("rst_no_beat", beat_seen, 0);
        peak = 1'b0;

        // table-driven rhythms
        foreach (tbl[v]) begin
            clear_dut(1'b0);
            beat_seen = 0;
            for (int b = 0; b < tbl[v].nbeats - 1; b++) rise_then(1'b0, tbl[v].gap * CLK_DIV, 2);
            peak = 1'b1;
            @(negedge clk);
            check("tbl_beat_pulse", beat, 1);
            @(negedge clk);
            peak = 1'b0;
            repeat (16) @(negedge clk);
            check("tbl_bpm_n17", bpm, tbl[v].pre_bpm);
            check("tbl_valid_n17", bpm_valid, tbl[v].pre_valid);
            @(negedge clk);
            check("tbl_bpm_n18", bpm, tbl[v].exp_bpm);
            check("tbl_valid_n18", bpm_valid, tbl[v].exp_valid);
            check("tbl_beat_count", beat_seen, tbl[v].exp_beats);
        end

        // asynchronous reset mid-count with peak high
        @(negedge clk);
        peak = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_bpm", bpm, 0);
        check("async_valid", bpm_valid, 0);
        check("async_beat", beat, 0);
        check("async_lost", lost, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        beat_seen = 0;
        repeat (12) @(negedge clk);
        check("post_rst_no_beat", beat_seen, 0);
        peak = 1'b0;

        // refractory: extra rise 10 ticks after a beat is ignored
        clear_dut(1'b0);
        beat_seen = 0;
        rise_then(1'b0, 300, 2);
        rise_then(1'b0, 300, 2);
        rise_then(1'b0, 40, 2);
        rise_then(1'b0, 1, 2);
        check("refract_no_beat", beat, 0);
        @(negedge clk);
        peak = 1'b0;
        repeat (258) @(negedge clk);
        rise_then(1'b0, 300, 2);
        rise_then(1'b0, 19, 2);
        check("refract_bpm", bpm, 80);
        check("refract_valid", bpm_valid, 1);
        check("refract_beats", beat_seen, 5);

        // timeout: 300th tick after the last beat lands 1198 edges later
        repeat (1179) @(negedge clk);
        check("timeout_before", lost, 0);
        @(negedge clk);
        check("timeout_lost", lost, 1);
        check("timeout_bpm", bpm, 0);
        check("timeout_valid", bpm_valid, 0);
        rise_then(1'b0, 1, 2);
        check("relock_beat", beat, 1);
        check("relock_lost", lost, 0);
        @(negedge clk);
        peak = 1'b0;
        repeat (30) @(negedge clk);
        check("relock_valid", bpm_valid, 0);

        // ena low at N+8 aborts the divide
        clear_dut(1'b0);
        for (int b = 0; b < 4; b++) rise_then(1'b0, 300, 2);
        rise_then(1'b0, 8, 2);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_bpm", bpm, 0);
        check("abort_valid", bpm_valid, 0);
        rise_then(1'b0, 1, 2);
        check("abort_idle_beat", beat, 1);
        @(negedge clk);
        peak = 1'b0;

        // saturation and averaging on the REFRACT=10 instance
        clear_dut(1'b1);
        for (int b = 0; b < 4; b++) rise_then(1'b1, 80, 2);
        rise_then(1'b1, 19, 2);
        check("sat_bpm", bpm2, 255);
        check("sat_valid", bpm_valid2, 1);
        repeat (141) @(negedge clk);
        rise_then(1'b1, 19, 2);
        check("avg25_bpm", bpm2, 240);
        repeat (141) @(negedge clk);
        rise_then(1'b1, 19, 2);
        check("avg30_bpm", bpm2, 200);
        check("avg30_lost", lost2, 0);
        check("avg30_beat", beat2, 0);

        // randomized traffic against the model
        for (int it = 0; it < 70; it++) begin
            int act;
            act = int'($urandom_range(0, 9));
            if (act < 6)       rise_then(1'b0, int'($urandom_range(200, 400)), int'($urandom_range(2, 6)));
            else if (act == 6) rise_then(1'b0, int'($urandom_range(8, 90)), int'($urandom_range(2, 6)));
            else if (act == 7) rise_then(1'b0, int'($urandom_range(1100, 1400)), 2);
            else if (act == 8) begin
                ena  = 1'b0;
                peak = 1'(int'($urandom_range(0, 1)));
                @(negedge clk);
                ena = 1'b1;
                peak = 1'b0;
                repeat (int'($urandom_range(1, 30))) @(negedge clk);
            end else begin
                rst_n = 1'b0;
                peak  = 1'(int'($urandom_range(0, 1)));
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (int'($urandom_range(1, 30))) @(negedge clk);
                peak = 1'b0;
                @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_heart_rate.md
# tt_heart_rate

Heart-rate meter downstream of the threshold filter `th_flt` in the TinyTapeout heart design. It consumes the filter's `peak` output, qualifies each rising edge as a beat with a refractory window, averages the last four beat-to-beat intervals, and converts the average to beats per minute with an iterative divider. It also flags signal loss.

## Interface
- `CLK_DIV`, default 1000: clock cycles per sample tick; must be ≥ 2.
- `TICK_HZ`, default 100: tick rate in Hz. The conversion constant K = 60·TICK_HZ must be ≤ 65535.
- `REFRACT`, default 25: minimum ticks between accepted beats; must be ≥ 1.
- `TIMEOUT`, default 300: ticks without a beat before signal loss is declared; must be > REFRACT.
- Constraint: CLK_DIV·REFRACT ≥ 20.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: low applies a synchronous clear to the reset state, except `peak_q`.
- `peak` in 1: peak level from `th_flt`.
- `bpm` out 8: beats per minute, saturated at 255.
- `bpm_valid` out 1: `bpm` holds a result computed from 4 intervals.
- `beat` out 1: one-cycle pulse per accepted beat.
- `lost` out 1: timeout has occurred and no beat has been accepted since.

## Operation
- **Prescaler.** `pre` counts 0..CLK_DIV-1. `tick` pulses on the cycle `pre` wraps.
- **Edge detection.** `peak_q` registers `peak`; `rise = peak & ~peak_q`. `peak_q` resets to 1, so a `peak` held high across reset does not produce a beat.
- **Interval counter.** `ivl` is 16 bits. It increments on `tick` and saturates at 65535.
- **Beat acceptance.** A beat is accepted when `rise` is true and either state = IDLE or `ivl` ≥ REFRACT. Otherwise the rise is ignored and nothing changes.
- **Actions on an accepted beat:**
  - Pulse `beat`, clear `lost`, set `ivl` to 0.
  - If state ≠ IDLE, push the old `ivl` into a 4-entry history shift register and increment `nvalid` (saturates at 4).
- **Main FSM:**
  - IDLE → ARMED on an accepted beat. ARMED means one beat seen, no interval yet.
  - ARMED → TRACK on an accepted beat. TRACK means intervals are being collected.
  - ARMED or TRACK → IDLE when `ivl` reaches TIMEOUT.
- **Timeout (`ivl` == TIMEOUT in ARMED or TRACK):** set `lost`=1, clear history, `nvalid`, `bpm` and `bpm_valid`, abort the divider, and go to IDLE. In IDLE, `ivl` holds.
- **Average.** When a push makes `nvalid`=4, or `nvalid` was already 4:
  - sum = sum of the 4 entries (18 bits).
  - avg = sum[17:2] (truncating).
- **Divider.** A restoring divider computes q = K / avg, 16 bits, one quotient bit per cycle. A new push while the divider is busy restarts it with the new avg.
- **Result.** At completion: `bpm` = min(q, 255) and `bpm_valid`=1. Before the first completion, `bpm` = 0.
- **Reset values:** `bpm`=0, `bpm_valid`=0, `beat`=0, `lost`=0, state IDLE, `ivl`=0, `pre`=0, `nvalid`=0, `peak_q`=1.

## Timing
- Let edge N be the first edge at which `peak`=1 and `peak_q`=0.
- At edge N: `beat`=1 (for the single cycle after N), `ivl` clears, and history is pushed.
- Edge N+1: the divider loads avg.
- Edges N+2..N+17: the 16 divider iterations.
- Edge N+18: `bpm` and `bpm_valid` update. End-to-end latency from the `peak` rise to `bpm` is 18 clocks.
- Timeout takes effect at the edge where `ivl` increments to TIMEOUT. All outputs update together at that edge.
- `rst_n` low clears everything immediately, including mid-divide. Release of reset is synchronous to `clk`.
- `ena` low for one edge performs a full clear; `peak_q` still tracks `peak`.
- A rise on the same edge as a timeout: the timeout is applied first, then the rise is accepted as an IDLE beat. Result: `lost`=0, state ARMED, `beat`=1.

## Test plan
Default bench parameters: CLK_DIV=4, TICK_HZ=100, REFRACT=25, TIMEOUT=300.

1. **Reset.** Assert `rst_n`=0 mid-count with `peak` high. Required: all outputs 0 asynchronously. After release with `peak` still high: no `beat`.
2. **Steady rhythm.** Peak rise every 75 ticks (300 clocks), 5 beats. Required: `beat` pulses 5 times; 18 clocks after the 5th beat `bpm`=80 (6000/75) and `bpm_valid`=1; `bpm` stays 0 before that.
3. **Refractory window.** Extra rise 10 ticks after an accepted beat in a 75-tick rhythm. Required: no `beat` pulse; the next `bpm` is still 80.
4. **Timeout.** Stop peaks after a valid lock. Required: at `ivl`=300, `lost`=1, `bpm`=0, `bpm_valid`=0. The next rise gives `beat`=1, `lost`=0, `bpm_valid` stays 0.
5. **Saturation and averaging.** With REFRACT=10:
   - Intervals 20, 20, 20, 20 → q=300 → `bpm`=255.
   - Then intervals 40, 40 → sum 120, avg 30 → `bpm`=200.
6. **Mid-divide disruption.** Drive `ena`=0 for one cycle at N+8. Required: the divider aborts, `bpm` stays 0, `bpm_valid`=0, state IDLE.
